instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Cycle-level controller for the 8227 core, sitting between the opcode register and the decoder. It owns the instruction cycle:
- fetch the opcode,
- give the decoder one cycle to settle,
- step through the addressing-mode cycles and then the operation cycles.

It also runs the post-reset and interrupt-entry sequences. Its `state`/`timeStep` outputs index the per-mode control-flag tables.

## Interface
- `RESET_CYCLES`, default 7: length of the post-reset sequence. Legal range 1..8.
- `INT_CYCLES`, default 7: length of the interrupt-entry sequence. Legal range 1..8.
- `clk` in 1: core clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: 1 = advance; 0 = stall.
- `addressTimingCode` in 3: number of addressing cycles for the current opcode, from the decoder.
- `opTimingCode` in 3: number of operation cycles for the current opcode, from the decoder.
- `earlyDone` in 1: terminates the current ADDR/OP phase after this cycle. Used for untaken branches and for no page cross.
- `nmi` in 1: non-maskable interrupt request, active-high, rising-edge sensitive.
- `irq` in 1: interrupt request, active-high, level sensitive.
- `iFlag` in 1: processor-status I bit; 1 masks `irq`.
- `state` out 3: RESET=0, FETCH=1, DECODE=2, ADDR=3, OP=4, INT=5.
- `timeStep` out 3: zero-based cycle index within the current state.
- `sync` out 1: high while state==FETCH (opcode fetch cycle).
- `loadIR` out 1: `sync & rdy`; loads the instruction register at the cycle end.
- `instrDone` out 1: high in the final cycle of an instruction, gated by `rdy`.
- `intSource` out 2: 00 reset, 01 NMI, 10 IRQ. Selects the vector.

## Operation
- **Registers:** `state`, `timeStep`, `addrLen`, `opLen`, `intSource`, `nmiPrev`, `nmiPending`. `sync`, `loadIR` and `instrDone` are combinational from the registers and `rdy`.
- **RESET:** `timeStep` counts 0..RESET_CYCLES-1, then goes to FETCH with `timeStep`=0.
- **FETCH:** lasts one cycle, then goes to DECODE.
- **DECODE:** lasts one cycle (operand-byte read).
  - Latches `addrLen`←`addressTimingCode` and `opLen`←`opTimingCode`.
  - Next state: ADDR if the code is nonzero; else OP if the op code is nonzero; else END.
- **ADDR:** steps 0..addrLen-1. On the last step, or on `earlyDone`: go to OP if `opLen`≠0, else END.
- **OP:** steps 0..opLen-1. On the last step, or on `earlyDone`: END.
- **END** is a transition, not a state. `instrDone` is high in that cycle; the next state is INT if an interrupt is pending, else FETCH.
- **Interrupt priority:** `nmiPending` beats `irq & ~iFlag`. On INT entry:
  - `intSource` is set to 01 or 10.
  - `nmiPending` clears only if NMI was taken.
- **INT:** steps 0..INT_CYCLES-1, then FETCH. `intSource` holds until the next INT entry.
- **NMI edge detect:**
  - `nmiPending` sets on `nmi & ~nmiPrev`.
  - The edge detector samples every cycle regardless of `rdy` or state.
  - An edge during INT stays pending and is serviced at the next END.
- **`earlyDone`:** ignored in RESET, FETCH, DECODE and INT.
- **`timeStep`:** resets to 0 on every state change.
- **Stall (`rdy`=0):** `state`, `timeStep`, `addrLen`, `opLen` and `intSource` all hold. `loadIR` and `instrDone` are forced to 0. `sync` still reflects the state.

## Timing
- **Reset values:** `state`=RESET, `timeStep`=0, `sync`=0, `loadIR`=0, `instrDone`=0, `intSource`=00, `nmiPending`=0, `nmiPrev`=0.
- **Reset mid-instruction:** returns to RESET immediately (asynchronous) and discards any pending NMI.
- **Instruction length:** 2 + addrLen + opLen cycles without `earlyDone`, with no overlap between instructions.
- **Decoder latency:** the decoder sees the new instruction register from the DECODE cycle. Codes are sampled only at the end of DECODE; later changes are ignored.
- **Interrupt sampling:** `irq` is sampled only in the END cycle; a pulse outside END is lost.
- **`earlyDone` on the last step:** same as normal completion.

## Configuration
- `SEQ_INTERRUPT_EN` defined: NMI/IRQ logic and the INT state are present, as described above.
- `SEQ_INTERRUPT_EN` undefined:
  - `nmi`, `irq` and `iFlag` are ignored.
  - END always goes to FETCH.
  - `intSource` is constant 00.
  - INT is unreachable and the interrupt logic is not synthesized.

## Test plan
- **Reset sequence:** release `rst` with `rdy`=1 → `state`=RESET for 7 cycles with `timeStep` 0..6; cycle 8 has `sync`=1 and `loadIR`=1.
- **Full-length instruction:** codes addr=2, op=3 → FETCH, DECODE, ADDR0, ADDR1, OP0, OP1, OP2, FETCH; `instrDone` only on OP2.
- **Zero-length codes:** both codes 0 → FETCH, DECODE (`instrDone`=1), FETCH. `earlyDone` at ADDR0 with addr=3, op=0 → FETCH follows ADDR0.
- **Stall:** `rdy`=0 for 3 cycles at OP1 → `state`/`timeStep` frozen, `loadIR`=`instrDone`=0; OP2 follows once `rdy`=1.
- **Interrupts (`SEQ_INTERRUPT_EN`):**
  - 1-cycle `nmi` pulse mid-OP together with `irq`=1, `iFlag`=0 → INT with `intSource`=01 for 7 cycles, then FETCH, then INT with `intSource`=10 at the next END.
  - With `iFlag`=1, IRQ is never taken.
- **Asynchronous reset mid-ADDR:** assert `rst` mid-ADDR → outputs at reset values before the next clock edge; a pending NMI is cleared.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Cycle-level instruction sequencer for the 8227 core: reset, fetch, decode, addressing,
// operation and interrupt-entry cycles. Define SEQ_INTERRUPT_EN to build the NMI/IRQ logic.
module instruction_sequencer #(
  parameter int unsigned RESET_CYCLES = 7,
  parameter int unsigned INT_CYCLES   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [2:0] addressTimingCode,
  input  logic [2:0] opTimingCode,
  input  logic       earlyDone,
  input  logic       nmi,
  input  logic       irq,
  input  logic       iFlag,
  output logic [2:0] state,
  output logic [2:0] timeStep,
  output logic       sync,
  output logic       loadIR,
  output logic       instrDone,
  output logic [1:0] intSource
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ADDR   = 3'd3;
  localparam logic [2:0] ST_OP     = 3'd4;
  localparam logic [2:0] ST_INT    = 3'd5;

  localparam logic [2:0] RESET_LAST = 3'(RESET_CYCLES - 1);
  localparam logic [2:0] INT_LAST   = 3'(INT_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] time_step_q, time_step_d;
  logic [2:0] addr_len_q, addr_len_d;
  logic [2:0] op_len_q, op_len_d;
  logic       instr_end;
  logic       int_req;

  always_comb begin
    state_d     = state_q;
    time_step_d = time_step_q;
    addr_len_d  = addr_len_q;
    op_len_d    = op_len_q;
    instr_end   = 1'b0;
    if (rdy) begin
      case (state_q)
        ST_RESET: begin
          if (time_step_q == RESET_LAST) state_d = ST_FETCH;
          else time_step_d = time_step_q + 3'd1;
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          addr_len_d = addressTimingCode;
          op_len_d   = opTimingCode;
          if (addressTimingCode != 3'd0) state_d = ST_ADDR;
          else if (opTimingCode != 3'd0) state_d = ST_OP;
          else instr_end = 1'b1;
        end
        ST_ADDR: begin
          if (time_step_q == addr_len_q - 3'd1 || earlyDone) begin
            if (op_len_q != 3'd0) state_d = ST_OP;
            else instr_end = 1'b1;
          end else begin
            time_step_d = time_step_q + 3'd1;
          end
        end
        ST_OP: begin
          if (time_step_q == op_len_q - 3'd1 || earlyDone) instr_end = 1'b1;
          else time_step_d = time_step_q + 3'd1;
        end
        ST_INT: begin
          if (time_step_q == INT_LAST) state_d = ST_FETCH;
          else time_step_d = time_step_q + 3'd1;
        end
        default: state_d = ST_FETCH;
      endcase
      // END is a transition: leave the current state for INT or the next fetch.
      if (instr_end) state_d = int_req ? ST_INT : ST_FETCH;
      if (state_d != state_q) time_step_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      time_step_q <= 3'd0;
      addr_len_q  <= 3'd0;
      op_len_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      time_step_q <= time_step_d;
      addr_len_q  <= addr_len_d;
      op_len_q    <= op_len_d;
    end
  end

`ifdef SEQ_INTERRUPT_EN
  logic [1:0] int_source_q, int_source_d;
  logic       nmi_prev_q, nmi_prev_d;
  logic       nmi_pending_q, nmi_pending_d;
  logic       take_nmi;

  assign int_req = nmi_pending_q | (irq & ~iFlag);

  always_comb begin
    int_source_d = int_source_q;
    nmi_prev_d   = nmi;
    take_nmi     = instr_end & nmi_pending_q;
    if (take_nmi) int_source_d = 2'b01;
    else if (instr_end && irq && !iFlag) int_source_d = 2'b10;
    // A fresh edge in the same cycle an NMI is taken stays pending.
    nmi_pending_d = (nmi_pending_q & ~take_nmi) | (nmi & ~nmi_prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_source_q  <= 2'b00;
      nmi_prev_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      int_source_q  <= int_source_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign intSource = int_source_q;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ^{nmi, irq, iFlag};
  assign int_req   = 1'b0;
  assign intSource = 2'b00;
`endif

  assign state     = state_q;
  assign timeStep  = time_step_q;
  assign sync      = (state_q == ST_FETCH);
  assign loadIR    = sync & rdy;
  assign instrDone = instr_end;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: per-cycle expected outputs are queued as
// stimulus is applied and compared when the cycle is sampled on the falling edge.
module tb_instruction_sequencer;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic [2:0] atc;
  logic [2:0] otc;
  logic       early;
  logic       nmi;
  logic       irq;
  logic       iflag;
  logic [2:0] state;
  logic [2:0] time_step;
  logic       sync;
  logic       load_ir;
  logic       instr_done;
  logic [1:0] int_source;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [10:0] exp_q[$];

  instruction_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .addressTimingCode(atc),
    .opTimingCode     (otc),
    .earlyDone        (early),
    .nmi              (nmi),
    .irq              (irq),
    .iFlag            (iflag),
    .state            (state),
    .timeStep         (time_step),
    .sync             (sync),
    .loadIR           (load_ir),
    .instrDone        (instr_done),
    .intSource        (int_source)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {state, timeStep, sync, loadIR, instrDone, intSource}.
  function automatic logic [10:0] ex(input logic [2:0] st, input logic [2:0] ts, input logic sy,
                                     input logic ld, input logic dn, input logic [1:0] src);
    return {st, ts, sy, ld, dn, src};
  endfunction

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got st/ts/sy/ld/dn/src=%b/%b/%b/%b/%b/%b want %b/%b/%b/%b/%b/%b", tag,
               got[10:8], got[7:5], got[4], got[3], got[2], got[1:0],
               want[10:8], want[7:5], want[4], want[3], want[2], want[1:0]);
    end
  endtask

  task automatic expect_cyc(input logic [10:0] want);
    exp_q.push_back(want);
  endtask

  task automatic sample(input string tag);
    logic [10:0] want;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      want = exp_q.pop_front();
      check_eq(tag, {state, time_step, sync, load_ir, instr_done, int_source}, want);
    end
  endtask

  task automatic cyc(input string tag, input logic [10:0] want);
    expect_cyc(want);
    @(negedge clk);
    sample(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    for (int i = 0; i < 7; i++) cyc("reset_seq", ex(3'd0, 3'(i), 1'b0, 1'b0, 1'b0, 2'b00));
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; atc = '0; otc = '0; early = 1'b0;
    nmi = 1'b0; irq = 1'b0; iflag = 1'b0;
    #1 rst = 1'b1;
    #2;
    expect_cyc(ex(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    sample("reset_values");
    @(posedge clk);
    #1 rst = 1'b0;
    reset_seq();

    // Full-length instruction; codes changed after DECODE must be ignored.
    atc = 3'd2; otc = 3'd3;
    cyc("full_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("full_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    atc = 3'd0; otc = 3'd0;
    cyc("full_addr0",  ex(3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("full_addr1",  ex(3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("full_op0",    ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("full_op1",    ex(3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("full_op2",    ex(3'd4, 3'd2, 1'b0, 1'b0, 1'b1, 2'b00));

    // Zero-length codes.
    cyc("zero_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("zero_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00));

    // earlyDone ignored in FETCH/DECODE, honoured in ADDR0.
    atc = 3'd3; otc = 3'd0; early = 1'b1;
    cyc("early_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("early_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("early_addr0",  ex(3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00));
    early = 1'b0;

    // Stalls in FETCH and at OP1.
    atc = 3'd1; otc = 3'd3; rdy = 1'b0;
    cyc("stall_fetch", ex(3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00));
    rdy = 1'b1;
    cyc("stall_fetch_go", ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("stall_decode",   ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("stall_addr0",    ex(3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("stall_op0",      ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall_op1_hold", ex(3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00));
    rdy = 1'b1;
    cyc("stall_op1_go", ex(3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("stall_op2",    ex(3'd4, 3'd2, 1'b0, 1'b0, 1'b1, 2'b00));

`ifdef SEQ_INTERRUPT_EN
    // NMI pulse with IRQ also asserted: NMI first, IRQ at the following END.
    atc = 3'd0; otc = 3'd2;
    cyc("int_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("int_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    nmi = 1'b1; irq = 1'b1;
    cyc("int_op0", ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    nmi = 1'b0;
    cyc("int_op1", ex(3'd4, 3'd1, 1'b0, 1'b0, 1'b1, 2'b00));
    for (int i = 0; i < 7; i++) cyc("int_nmi_seq", ex(3'd5, 3'(i), 1'b0, 1'b0, 1'b0, 2'b01));
    cyc("irq_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b01));
    cyc("irq_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b01));
    cyc("irq_op0",    ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 2'b01));
    cyc("irq_op1",    ex(3'd4, 3'd1, 1'b0, 1'b0, 1'b1, 2'b01));
    for (int i = 0; i < 7; i++) cyc("int_irq_seq", ex(3'd5, 3'(i), 1'b0, 1'b0, 1'b0, 2'b10));
    iflag = 1'b1;
    cyc("mask_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b10));
    cyc("mask_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b10));
    cyc("mask_op0",    ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 2'b10));
    cyc("mask_op1",    ex(3'd4, 3'd1, 1'b0, 1'b0, 1'b1, 2'b10));
    irq = 1'b0; iflag = 1'b0;
`else
    // Interrupt inputs have no effect without the interrupt logic.
    atc = 3'd0; otc = 3'd1;
    cyc("noint_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("noint_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    nmi = 1'b1; irq = 1'b1;
    cyc("noint_op0", ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00));
    nmi = 1'b0;
    cyc("noint_fetch2",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("noint_decode2", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("noint_op0b",    ex(3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00));
    irq = 1'b0;
`endif

    // Asynchronous reset mid-ADDR with an NMI pending.
    atc = 3'd3; otc = 3'd0;
    cyc("ar_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("ar_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    nmi = 1'b1;
    cyc("ar_addr0", ex(3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    nmi = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_cyc(ex(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00));
    sample("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    reset_seq();
    atc = 3'd0; otc = 3'd0;
    cyc("post_fetch",  ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));
    cyc("post_decode", ex(3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 2'b00));
    cyc("post_no_int", ex(3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
